// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : N-master memory arbiter. Collects per-master requests, grants
//            one master at a time (fixed priority or round-robin) and drives a
//            single memory port with a ready handshake. Every transfer runs
//            IDLE -> BUSY -> RESP, so a zero-wait memory serves one request
//            every three cycles.
// Ports    : HCLK    - clock, rising edge
//            HRESET  - synchronous active-low reset
//            HTRANS  - per-master request, held until that master's HREADY
//            HADDR   - packed per-master addresses (master i at i*ADDR_WIDTH)
//            HWRITE  - per-master write enable
//            HWDATA  - packed per-master write data (master i at i*DATA_WIDTH)
//            HREADY  - one-cycle completion pulse to the served master
//            HRDATA  - read data, broadcast, valid while HREADY pulses
//            stall   - per-master pipeline hold
//            PVALID  - memory request valid
//            PADDR   - memory address
//            PWRITE  - memory write enable
//            PDATA   - memory write data
//            PREADY  - memory accepts/completes the current request
//            PRDATA  - memory read data, valid with PREADY
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_WIDTH  = 64,
   parameter int DATA_WIDTH  = 64,
   parameter int RR_MODE     = 0
) (
   input  logic                              HCLK,
   input  logic                              HRESET,
   input  logic [NUM_MASTERS-1:0]            HTRANS,
   input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] HADDR,
   input  logic [NUM_MASTERS-1:0]            HWRITE,
   input  logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATA,
   output logic [NUM_MASTERS-1:0]            HREADY,
   output logic [DATA_WIDTH-1:0]             HRDATA,
   output logic [NUM_MASTERS-1:0]            stall,
   output logic                              PVALID,
   output logic [ADDR_WIDTH-1:0]             PADDR,
   output logic                              PWRITE,
   output logic [DATA_WIDTH-1:0]             PDATA,
   input  logic                              PREADY,
   input  logic [DATA_WIDTH-1:0]             PRDATA
);

   localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [IDX_W-1:0]        grant;
   logic [IDX_W-1:0]        last_grant;
   logic [IDX_W-1:0]        win_idx;
   logic                    win_found;
   logic [NUM_MASTERS-1:0]  grant_onehot;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic                    sel_write;
   logic [DATA_WIDTH-1:0]   sel_wdata;

   // Winner search. Fixed priority starts at master 0; round-robin starts
   // just after the last granted master and wraps around.
   always_comb begin
      int start;
      int cand;
      win_found = 1'b0;
      win_idx   = '0;
      start     = (RR_MODE != 0) ? int'(last_grant) + 1 : 0;
      if (start >= NUM_MASTERS) begin
         start = 0;
      end
      for (int off = 0; off < NUM_MASTERS; off++) begin
         cand = start + off;
         if (cand >= NUM_MASTERS) begin
            cand = cand - NUM_MASTERS;
         end
         if (!win_found && HTRANS[IDX_W'(cand)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(cand);
         end
      end
   end

   // Request fields of the winning master.
   always_comb begin
      sel_addr  = '0;
      sel_write = 1'b0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (win_idx == IDX_W'(i)) begin
            sel_addr  = HADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_write = HWRITE[i];
            sel_wdata = HWDATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_comb begin
      grant_onehot        = '0;
      grant_onehot[grant] = 1'b1;
   end

   // Only the master being acknowledged is released; everyone else with a
   // live request keeps stalling.
   assign stall = HTRANS & ~((state == RESP) ? grant_onehot : '0);

   always_ff @(posedge HCLK) begin
      if (!HRESET) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (win_found) state_nxt = BUSY;
         BUSY:    if (PREADY)    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory port and response registers. PREADY is only looked at in BUSY;
   // RESP performs no arbitration so the served master can retire its request.
   always_ff @(posedge HCLK) begin
      if (!HRESET) begin
         PVALID     <= 1'b0;
         PADDR      <= '0;
         PWRITE     <= 1'b0;
         PDATA      <= '0;
         HREADY     <= '0;
         HRDATA     <= '0;
         grant      <= '0;
         last_grant <= LAST_IDX;
      end else begin
         case (state)
            IDLE: begin
               if (win_found) begin
                  PVALID     <= 1'b1;
                  PADDR      <= sel_addr;
                  PWRITE     <= sel_write;
                  PDATA      <= sel_wdata;
                  grant      <= win_idx;
                  last_grant <= win_idx;
               end
            end
            BUSY: begin
               if (PREADY) begin
                  HRDATA <= PRDATA;
                  PVALID <= 1'b0;
                  HREADY <= grant_onehot;
               end
            end
            RESP: begin
               HREADY <= '0;
            end
            default: begin
               HREADY <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Two instances share one
//            stimulus set: a 2-master fixed-priority arbiter and a 4-master
//            round-robin arbiter; sel_b chooses which one is observed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic              clk;
   logic              rstn;
   logic [3:0]        trans;
   logic [3:0]        hwrite;
   logic [4*AW-1:0]   haddr;
   logic [4*DW-1:0]   hwdata;
   logic              pready;
   logic [DW-1:0]     prdata;

   logic [1:0]        a_hready, a_stall;
   logic [DW-1:0]     a_hrdata, a_pdata;
   logic [AW-1:0]     a_paddr;
   logic              a_pvalid, a_pwrite;

   logic [3:0]        b_hready, b_stall;
   logic [DW-1:0]     b_hrdata, b_pdata;
   logic [AW-1:0]     b_paddr;
   logic              b_pvalid, b_pwrite;

   logic              sel_b;
   logic [3:0]        o_hready, o_stall;
   logic [DW-1:0]     o_hrdata, o_pdata;
   logic [AW-1:0]     o_paddr;
   logic              o_pvalid, o_pwrite;

   int checks;
   int errors;

   mem_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(0)) dut_a (
      .HCLK(clk), .HRESET(rstn), .HTRANS(trans[1:0]), .HADDR(haddr[2*AW-1:0]),
      .HWRITE(hwrite[1:0]), .HWDATA(hwdata[2*DW-1:0]), .HREADY(a_hready),
      .HRDATA(a_hrdata), .stall(a_stall), .PVALID(a_pvalid), .PADDR(a_paddr),
      .PWRITE(a_pwrite), .PDATA(a_pdata), .PREADY(pready), .PRDATA(prdata));

   mem_arbiter #(.NUM_MASTERS(4), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(1)) dut_b (
      .HCLK(clk), .HRESET(rstn), .HTRANS(trans), .HADDR(haddr),
      .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(b_hready),
      .HRDATA(b_hrdata), .stall(b_stall), .PVALID(b_pvalid), .PADDR(b_paddr),
      .PWRITE(b_pwrite), .PDATA(b_pdata), .PREADY(pready), .PRDATA(prdata));

   always_comb begin
      if (sel_b) begin
         o_hready = b_hready; o_stall = b_stall; o_hrdata = b_hrdata;
         o_pdata  = b_pdata;  o_paddr = b_paddr; o_pvalid = b_pvalid;
         o_pwrite = b_pwrite;
      end else begin
         o_hready = {2'b00, a_hready}; o_stall = {2'b00, a_stall};
         o_hrdata = a_hrdata; o_pdata = a_pdata; o_paddr = a_paddr;
         o_pvalid = a_pvalid; o_pwrite = a_pwrite;
      end
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic w,
                          input logic [DW-1:0] d);
      trans[i]            = 1'b1;
      hwrite[i]           = w;
      haddr[i*AW +: AW]   = a;
      hwdata[i*DW +: DW]  = d;
   endtask

   task automatic reset_all();
      rstn = 1'b0; trans = '0; hwrite = '0; haddr = '0; hwdata = '0;
      pready = 1'b0; prdata = '0;
      step();
      step();
      rstn = 1'b1;
   endtask

   // Arbitration rule: fixed priority takes the lowest index; round-robin
   // takes the first requester after the previous winner, wrapping.
   function automatic int pick(input logic [3:0] req, input int last, input bit rr,
                               input int n);
      for (int off = 0; off < n; off++) begin
         int idx;
         idx = rr ? (last + 1 + off) % n : off;
         if (req[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic test_reset();
      rstn = 1'b0; trans = '0; hwrite = '0; haddr = '0; hwdata = '0;
      pready = 1'b1; prdata = 32'hDEADBEEF;
      step();
      step();
      for (int s = 0; s < 2; s++) begin
         sel_b = s[0];
         #1;
         checks++;
         if (o_pvalid !== 1'b0 || o_paddr !== '0 || o_pwrite !== 1'b0 || o_pdata !== '0 ||
             o_hready !== 4'b0 || o_hrdata !== '0 || o_stall !== 4'b0) begin
            errors++;
            $display("FAIL reset_outputs dut=%0d got pv=%b pa=%h pw=%b pd=%h hr=%b hd=%h st=%b exp all zero",
                     s, o_pvalid, o_paddr, o_pwrite, o_pdata, o_hready, o_hrdata, o_stall);
         end
      end
      sel_b = 1'b0;
      rstn  = 1'b1;
      set_req(1, 32'h1000, 1'b0, '0);
      #1;
      checks++;
      if (o_stall !== 4'b0010) begin
         errors++; $display("FAIL reset_first_stall got %b exp 0010", o_stall);
      end
      step();
      checks++;
      if (o_pvalid !== 1'b1 || o_paddr !== 32'h1000 || o_pwrite !== 1'b0 || o_hready !== 4'b0) begin
         errors++;
         $display("FAIL reset_first_issue got pv=%b pa=%h pw=%b hr=%b exp pv=1 pa=1000 pw=0 hr=0000",
                  o_pvalid, o_paddr, o_pwrite, o_hready);
      end
      step();
      checks++;
      if (o_hready !== 4'b0010 || o_hrdata !== 32'hDEADBEEF || o_pvalid !== 1'b0 || o_stall !== 4'b0) begin
         errors++;
         $display("FAIL reset_first_resp got hr=%b hd=%h pv=%b st=%b exp hr=0010 hd=deadbeef pv=0 st=0000",
                  o_hready, o_hrdata, o_pvalid, o_stall);
      end
      trans = '0;
      step();
      checks++;
      if (o_hready !== 4'b0 || o_pvalid !== 1'b0) begin
         errors++; $display("FAIL reset_first_done got hr=%b pv=%b exp 0000 0", o_hready, o_pvalid);
      end
   endtask

   task automatic test_fixed_priority();
      int exp_hr[7];
      logic [3:0] e;
      sel_b = 1'b0;
      reset_all();
      pready = 1'b1;
      set_req(0, 32'h10, 1'b1, 32'hAA);
      set_req(1, 32'h20, 1'b0, 32'h0);
      exp_hr = '{0, 1, 0, 0, 2, 0, 0};
      for (int c = 1; c <= 7; c++) begin
         step();
         e = 4'(exp_hr[c-1]);
         checks++;
         if (o_hready !== e) begin
            errors++; $display("FAIL fixed_hready cyc=%0d got %b exp %b", c, o_hready, e);
         end
         checks++;
         if (o_stall !== (trans & ~e)) begin
            errors++; $display("FAIL fixed_stall cyc=%0d got %b exp %b", c, o_stall, trans & ~e);
         end
         if (c == 1) begin
            checks++;
            if (o_pvalid !== 1'b1 || o_paddr !== 32'h10 || o_pwrite !== 1'b1 || o_pdata !== 32'hAA) begin
               errors++;
               $display("FAIL fixed_m0_issue got pv=%b pa=%h pw=%b pd=%h exp 1 10 1 aa",
                        o_pvalid, o_paddr, o_pwrite, o_pdata);
            end
         end
         if (c == 4) begin
            checks++;
            if (o_pvalid !== 1'b1 || o_paddr !== 32'h20 || o_pwrite !== 1'b0) begin
               errors++;
               $display("FAIL fixed_m1_issue got pv=%b pa=%h pw=%b exp 1 20 0", o_pvalid, o_paddr, o_pwrite);
            end
         end
         trans = trans & ~e;
      end
   endtask

   task automatic test_round_robin();
      int order[6];
      int g;
      int last_c;
      sel_b = 1'b1;
      reset_all();
      pready = 1'b1;
      for (int i = 0; i < 4; i++) set_req(i, 32'(32'h100 * i), 1'b0, '0);
      order  = '{0, 1, 2, 3, 0, 1};
      g      = 0;
      last_c = 0;
      for (int c = 1; c <= 40 && g < 6; c++) begin
         step();
         if (o_hready !== 4'b0) begin
            checks++;
            if (o_hready !== 4'(1 << order[g])) begin
               errors++; $display("FAIL rr_order grant=%0d got %b exp %b", g, o_hready, 4'(1 << order[g]));
            end
            if (g > 0) begin
               checks++;
               if (c - last_c != 3) begin
                  errors++; $display("FAIL rr_spacing grant=%0d got %0d exp 3", g, c - last_c);
               end
            end
            last_c = c;
            g++;
         end
      end
      checks++;
      if (g != 6) begin
         errors++; $display("FAIL rr_timeout got %0d grants exp 6", g);
      end
      trans = '0;
   endtask

   task automatic test_wait_states();
      int pulses;
      int pulse_c;
      sel_b = 1'b0;
      reset_all();
      set_req(0, 32'h55, 1'b1, 32'h12345678);
      pulses  = 0;
      pulse_c = 0;
      for (int c = 1; c <= 8; c++) begin
         step();
         if (c <= 4) begin
            checks++;
            if (o_pvalid !== 1'b1 || o_paddr !== 32'h55 || o_pdata !== 32'h12345678 ||
                o_stall !== 4'b0001) begin
               errors++;
               $display("FAIL wait_hold cyc=%0d got pv=%b pa=%h pd=%h st=%b exp 1 55 12345678 0001",
                        c, o_pvalid, o_paddr, o_pdata, o_stall);
            end
         end
         if (o_hready !== 4'b0) begin
            pulses++;
            pulse_c = c;
            trans   = '0;
         end
         pready = (c == 4);
      end
      checks++;
      if (pulses != 1 || pulse_c != 5) begin
         errors++; $display("FAIL wait_pulse got %0d pulses at cyc %0d exp 1 at 5", pulses, pulse_c);
      end
   endtask

   task automatic test_reset_mid_busy();
      sel_b = 1'b1;
      reset_all();
      pready = 1'b1;
      set_req(1, 32'h111, 1'b0, '0);
      step();
      step();
      checks++;
      if (o_hready !== 4'b0010) begin
         errors++; $display("FAIL midrst_setup got %b exp 0010", o_hready);
      end
      trans = '0; pready = 1'b0;
      step();
      set_req(2, 32'h222, 1'b1, 32'h5);
      step();
      checks++;
      if (o_pvalid !== 1'b1 || o_paddr !== 32'h222) begin
         errors++; $display("FAIL midrst_busy got pv=%b pa=%h exp 1 222", o_pvalid, o_paddr);
      end
      rstn = 1'b0;
      step();
      checks++;
      if (o_pvalid !== 1'b0 || o_hready !== 4'b0) begin
         errors++; $display("FAIL midrst_abort got pv=%b hr=%b exp 0 0000", o_pvalid, o_hready);
      end
      rstn  = 1'b1;
      trans = '0;
      set_req(1, 32'h111, 1'b0, '0);
      set_req(3, 32'h333, 1'b0, '0);
      step();
      checks++;
      if (o_pvalid !== 1'b1 || o_paddr !== 32'h111 || o_hready !== 4'b0) begin
         errors++;
         $display("FAIL midrst_rearb got pv=%b pa=%h hr=%b exp 1 111 0000", o_pvalid, o_paddr, o_hready);
      end
      pready = 1'b1;
      step();
      checks++;
      if (o_hready !== 4'b0010) begin
         errors++; $display("FAIL midrst_done got %b exp 0010", o_hready);
      end
      trans = '0; pready = 1'b0;
      step();
   endtask

   task automatic test_drop_during_busy();
      int pulses;
      sel_b = 1'b0;
      reset_all();
      set_req(1, 32'h77, 1'b0, '0);
      step();
      checks++;
      if (o_pvalid !== 1'b1 || o_paddr !== 32'h77) begin
         errors++; $display("FAIL drop_issue got pv=%b pa=%h exp 1 77", o_pvalid, o_paddr);
      end
      trans = '0;
      step();
      step();
      checks++;
      if (o_pvalid !== 1'b1 || o_stall !== 4'b0) begin
         errors++; $display("FAIL drop_hold got pv=%b st=%b exp 1 0000", o_pvalid, o_stall);
      end
      pready = 1'b1; prdata = 32'hCAFE;
      step();
      checks++;
      if (o_hready !== 4'b0010 || o_hrdata !== 32'hCAFE) begin
         errors++; $display("FAIL drop_resp got hr=%b hd=%h exp 0010 cafe", o_hready, o_hrdata);
      end
      pready = 1'b0;
      pulses = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if (o_hready !== 4'b0) pulses++;
      end
      checks++;
      if (pulses != 0 || o_pvalid !== 1'b0) begin
         errors++; $display("FAIL drop_after got pulses=%0d pv=%b exp 0 0", pulses, o_pvalid);
      end
   endtask

   // Transaction-level model: a grant happens on an edge where no transfer is
   // in flight and the previous edge did not complete one; the transfer ends
   // on the first edge with PREADY high and is acknowledged to its master.
   task automatic test_random(input bit rr, input int cycles);
      int n, last, cur, w;
      bit in_flight, dead;
      logic [3:0]    req_b, exp_hr, exp_st;
      logic          exp_pv, p_b;
      logic [DW-1:0] pd_b, m_data;
      logic [AW-1:0] m_addr;
      logic          m_wr;
      sel_b = rr;
      n     = rr ? 4 : 2;
      reset_all();
      last = n - 1; cur = 0; in_flight = 0; dead = 0;
      m_addr = '0; m_wr = 1'b0; m_data = '0;
      for (int c = 0; c < cycles; c++) begin
         for (int i = 0; i < n; i++) begin
            if (!trans[i] && $urandom_range(0, 2) == 0)
               set_req(i, $urandom, 1'($urandom_range(0, 1)), $urandom);
         end
         pready = ($urandom_range(0, 2) != 0);
         prdata = $urandom;
         req_b = trans; p_b = pready; pd_b = prdata;
         step();
         exp_hr = '0;
         exp_pv = 1'b0;
         if (in_flight) begin
            if (p_b) begin
               exp_hr[cur] = 1'b1; in_flight = 0; dead = 1;
            end else begin
               exp_pv = 1'b1;
            end
         end else if (dead) begin
            dead = 0;
         end else begin
            w = pick(req_b, last, rr, n);
            if (w >= 0) begin
               cur = w; last = w; in_flight = 1; exp_pv = 1'b1;
               m_addr = haddr[w*AW +: AW]; m_wr = hwrite[w]; m_data = hwdata[w*DW +: DW];
            end
         end
         exp_st = trans & ~exp_hr;
         checks++;
         if (o_pvalid !== exp_pv || o_hready !== exp_hr) begin
            errors++;
            $display("FAIL rand_ctrl rr=%0d cyc=%0d got pv=%b hr=%b exp pv=%b hr=%b",
                     rr, c, o_pvalid, o_hready, exp_pv, exp_hr);
         end
         checks++;
         if (o_stall !== exp_st) begin
            errors++; $display("FAIL rand_stall rr=%0d cyc=%0d got %b exp %b", rr, c, o_stall, exp_st);
         end
         if (exp_pv) begin
            checks++;
            if (o_paddr !== m_addr || o_pwrite !== m_wr || o_pdata !== m_data) begin
               errors++;
               $display("FAIL rand_port rr=%0d cyc=%0d got %h %b %h exp %h %b %h",
                        rr, c, o_paddr, o_pwrite, o_pdata, m_addr, m_wr, m_data);
            end
         end
         if (exp_hr != 4'b0) begin
            checks++;
            if (o_hrdata !== pd_b) begin
               errors++; $display("FAIL rand_rdata rr=%0d cyc=%0d got %h exp %h", rr, c, o_hrdata, pd_b);
            end
            trans[cur] = 1'b0;
         end
      end
      trans = '0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      sel_b  = 1'b0;
      rstn   = 1'b0;
      trans  = '0; hwrite = '0; haddr = '0; hwdata = '0;
      pready = 1'b0; prdata = '0;
      test_reset();
      test_fixed_priority();
      test_round_robin();
      test_wait_states();
      test_reset_mid_busy();
      test_drop_during_busy();
      test_random(1'b0, 300);
      test_random(1'b1, 400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
